// File: rtl/data_mem_ctrl_pkg.sv
// data_mem_ctrl_pkg: shared state encoding and default timing/address constants for the memory stage
package data_mem_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;
  localparam int          DEF_WORDS       = 64;
  localparam int          DEF_WAIT_CYCLES = 3;
  localparam logic [31:0] DEF_BASE_ADDR   = 32'd1024;
endpackage

// File: rtl/data_mem_array.sv
// data_mem_array: single-port word array with a registered read port
module data_mem_array #(
  parameter int WORDS = 64,
  parameter int IW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic          hit,
  input  logic [IW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rd
);
  logic [31:0] r_mem [WORDS];
  logic [31:0] r_rd;
  always_ff @(posedge clk) begin
    if (we) r_mem[idx] <= wdata;
  end
  // a load that misses the array still completes, returning zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rd <= '0;
    else if (re) r_rd <= hit ? r_mem[idx] : '0;
  end
  assign rd = r_rd;
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: memory-stage responder with fixed wait states, pipeline freeze and range check
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int          WORDS       = DEF_WORDS,
  parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_enable,
  input  logic        mem_write_enable,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        freeze,
  output logic        addr_err
);
  localparam int          IW       = $clog2(WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYCLES - 1);
  localparam logic [29:0] WORDS_W  = 30'(WORDS);
  state_t        r_state, w_next;
  logic [3:0]    r_cnt;
  logic          r_ready, r_err;
  logic [29:0]   w_word;
  logic          w_in_range, w_req, w_fire, w_we, w_re;
  // (addr - BASE_ADDR) >> 2 without leaving the two low difference bits dangling
  assign w_word     = addr[31:2] - BASE_ADDR[31:2] - 30'(addr[1:0] < BASE_ADDR[1:0]);
  assign w_in_range = (addr >= BASE_ADDR) && (w_word < WORDS_W);
  assign w_req      = mem_read_enable | mem_write_enable;
  assign w_fire     = (r_state == BUSY) && (r_cnt == 4'd0);
  assign w_we       = w_fire & mem_write_enable & w_in_range;
  assign w_re       = w_fire & mem_read_enable & ~mem_write_enable;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = (r_state == IDLE) ? (w_req ? BUSY : IDLE) :
             (r_state == BUSY) ? (r_cnt == 4'd0 ? DONE : BUSY) : IDLE;
  end
  always_comb begin
    freeze = ((r_state == IDLE) & w_req) | (r_state == BUSY);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_cnt   <= (r_state == IDLE && w_req) ? CNT_INIT :
                 (r_state == BUSY && r_cnt != 4'd0) ? r_cnt - 4'd1 : r_cnt;
      r_ready <= w_fire;
      r_err   <= w_fire & ~w_in_range;
    end
  end
  data_mem_array #(.WORDS(WORDS), .IW(IW)) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (w_we),
    .re    (w_re),
    .hit   (w_in_range),
    .idx   (w_word[IW-1:0]),
    .wdata (wdata),
    .rd    (rdata)
  );
  assign ready    = r_ready;
  assign addr_err = r_err;
endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Memory-stage responder for the address and store data produced by the execute stage. It takes alu_out as a byte address and Val_Rm as store data, and services word loads and stores against an internal word array with a fixed number of wait states. While an access is in flight it raises freeze to stall the pipeline, then drops freeze and presents the load result for one advance cycle.

Parameters:
WORDS, 64, number of 32-bit words in the array (power of two)
WAIT_CYCLES, 3, wait states per access; legal range 1..15
BASE_ADDR, 1024, byte address that maps to word 0

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
mem_read_enable  input  1  load request, held stable while freeze=1
mem_write_enable  input  1  store request, held stable while freeze=1
addr  input  32  byte address (execute-stage alu_out)
wdata  input  32  store data (execute-stage Val_Rm)
rdata  output  32  load result
ready  output  1  one-cycle pulse: access completed this cycle
freeze  output  1  stall request to all upstream pipeline registers
addr_err  output  1  one-cycle pulse with ready when the access was out of range

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0, rdata=0, ready=0, addr_err=0. freeze follows its combinational rule, so it is 0 in IDLE with no request. Array contents are not reset and are undefined.
- Index: idx = (addr - BASE_ADDR) >> 2, 32-bit unsigned subtract. addr[1:0] is ignored (word access only).
- In range: addr >= BASE_ADDR and idx < WORDS. Otherwise the access is out of range.
- Request: req = mem_read_enable | mem_write_enable. When both are high, the access is a store and rdata is unchanged.
- States:
  - IDLE: if req, go to BUSY and load counter = WAIT_CYCLES-1. Otherwise stay.
  - BUSY: if counter==0, go to DONE. Otherwise decrement counter.
  - DONE: always go to IDLE.
- The access is performed on the BUSY->DONE edge:
  - Store in range: array[idx] <= wdata.
  - Load in range: rdata <= array[idx].
  - Load out of range: rdata <= 0.
  - Store out of range: dropped.
- ready=1 and addr_err (if applicable) are registered and asserted only in DONE.
- freeze = (state==IDLE & req) | (state==BUSY). It is combinational and is 0 in DONE so the pipeline advances exactly once.
- Latency: request seen in IDLE at cycle 0; BUSY for cycles 1..WAIT_CYCLES; DONE at cycle WAIT_CYCLES+1.
  - freeze is high for WAIT_CYCLES+1 cycles.
  - rdata is valid from DONE and held until the next load completes.
- Back-to-back: the request present in the cycle after DONE is a new instruction and starts a fresh access. There are no idle cycles beyond the mandatory DONE.
- No request in IDLE: freeze=0, no array access, outputs hold.
- Request dropped while in BUSY: protocol violation. The access still completes using the current addr/wdata at the BUSY->DONE edge.
- Reset mid-access (BUSY or DONE): abort, return to IDLE. A pending store is not written. rdata clears to 0.
- Counter width: 4 bits.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and the default WAIT_CYCLES/BASE_ADDR constants, so the pipeline top and the forwarding/hazard logic can reference the same values.
- One natural sub-module: data_mem_array.
  - Synchronous single-port WORDS x 32 array.
  - Inputs: we, idx, wdata, re.
  - Output: registered rd.
- The controller holds the FSM, range check and freeze logic.

Test Plan:
- Reset, then store addr=1024, wdata=0xDEADBEEF (W=3) -> freeze high for 4 cycles, ready pulses in cycle 4, freeze=0 in cycle 4.
- Load addr=1024 after that store -> rdata=0xDEADBEEF in DONE, held through 3 following idle cycles.
- Store addr=1028, wdata=0x11, immediately followed by a load of addr=1028 the cycle after DONE -> second access starts without gap; rdata=0x11.
- Load addr=1000 and load addr=1024+4*WORDS -> rdata=0, addr_err=1 with ready. A store to 1000 leaves word 0 unchanged (verified by reload).
- Both enables high, addr=1032, wdata=0x55 -> treated as store: rdata unchanged; a later load of 1032 returns 0x55.
- Assert rst=0 mid-BUSY of a store to 1036 with wdata=0x77 -> outputs clear asynchronously, state IDLE, freeze=0. After release, reloading 1036 does not return 0x77 (the prior value is written first by the bench to establish this).
